// File: rtl/f1_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module      : f1_reaction_timer
// Description : Measures driver reaction time (ms) from lights-out to trigger
//               press on the start-light bar. Flags jump starts and no-press
//               timeouts. Optional best-time register when F1_REACT_BEST_EN
//               is defined (adds output best_ms).
// Revision    : 1.0 - initial release
// ============================================================================
module f1_reaction_timer #(
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_ms,
    input  logic [7:0]           lights,
    input  logic                 trigger,
    output logic [CNT_WIDTH-1:0] react_ms,
    output logic                 valid,
    output logic                 jump_start,
    output logic                 timeout,
    output logic                 busy
`ifdef F1_REACT_BEST_EN
    ,
    output logic [CNT_WIDTH-1:0] best_ms
`endif
);

    localparam logic [CNT_WIDTH-1:0] C_TIMEOUT = CNT_WIDTH'(TIMEOUT_MS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_TIMING = 3'd2,
        S_DONE   = 3'd3,
        S_FOUL   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1, r_sync2, r_sync3;
    logic                 w_press;
    logic [CNT_WIDTH-1:0] r_count, w_count_nxt, w_count_inc;
    logic [CNT_WIDTH-1:0] r_react, w_react_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic                 r_seen_full, w_seen_full_nxt;
    logic                 r_cleared, w_cleared_nxt;
`ifdef F1_REACT_BEST_EN
    logic [CNT_WIDTH-1:0] r_best, w_best_nxt;
`endif

    // Bring the asynchronous button into clk domain and keep a delayed copy for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= trigger;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // A held button produces exactly one press on its rising edge
    assign w_press     = r_sync2 & ~r_sync3;
    assign w_count_inc = r_count + 1'b1;

    // State register and all registered datapath values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_react     <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_seen_full <= 1'b0;
            r_cleared   <= 1'b0;
`ifdef F1_REACT_BEST_EN
            r_best      <= '1;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_react     <= w_react_nxt;
            r_valid     <= w_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_seen_full <= w_seen_full_nxt;
            r_cleared   <= w_cleared_nxt;
`ifdef F1_REACT_BEST_EN
            r_best      <= w_best_nxt;
`endif
        end
    end

    // Next-state and next-value decode; press outranks every other event
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_react_nxt     = r_react;
        w_valid_nxt     = 1'b0;
        w_timeout_nxt   = r_timeout;
        w_seen_full_nxt = r_seen_full;
        w_cleared_nxt   = r_cleared;
`ifdef F1_REACT_BEST_EN
        w_best_nxt      = r_best;
`endif
        case (r_state)
            S_IDLE: begin
                if (lights != 8'h00) begin
                    w_state_nxt     = S_ARMED;
                    w_seen_full_nxt = 1'b0;
                end
            end
            S_ARMED: begin
                if (w_press) begin
                    w_state_nxt   = S_FOUL;
                    w_cleared_nxt = 1'b0;
                end else if (lights == 8'hFF) begin
                    w_seen_full_nxt = 1'b1;
                end else if (lights == 8'h00) begin
                    if (r_seen_full) begin
                        w_state_nxt = S_TIMING;
                        w_count_nxt = '0;
                    end else begin
                        // Bar went dark without ever being full: aborted sequence
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_TIMING: begin
                if (w_press) begin
                    // Capture excludes any tick arriving in the same cycle
                    w_state_nxt   = S_DONE;
                    w_react_nxt   = r_count;
                    w_valid_nxt   = 1'b1;
                    w_timeout_nxt = 1'b0;
`ifdef F1_REACT_BEST_EN
                    if (r_count < r_best) begin
                        w_best_nxt = r_count;
                    end
`endif
                end else if (tick_ms) begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == C_TIMEOUT) begin
                        w_state_nxt   = S_DONE;
                        w_react_nxt   = C_TIMEOUT;
                        w_valid_nxt   = 1'b1;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (lights != 8'h00) begin
                    w_state_nxt     = S_ARMED;
                    w_timeout_nxt   = 1'b0;
                    w_seen_full_nxt = 1'b0;
                end
            end
            S_FOUL: begin
                // Re-arm only after the bar has gone dark and then lit again
                if (lights == 8'h00) begin
                    w_cleared_nxt = 1'b1;
                end else if (r_cleared) begin
                    w_state_nxt     = S_ARMED;
                    w_seen_full_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign react_ms   = r_react;
    assign valid      = r_valid;
    assign timeout    = r_timeout;
    assign jump_start = (r_state == S_FOUL);
    assign busy       = (r_state == S_ARMED) | (r_state == S_TIMING);
`ifdef F1_REACT_BEST_EN
    assign best_ms    = r_best;
`endif

endmodule
`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_f1_reaction_timer
// Description : Self-checking bench for f1_reaction_timer with randomized
//               tick spacing, press alignment and hold times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f1_reaction_timer;

    localparam int CW  = 16;
    localparam int TMO = 400;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick_ms = 1'b0;
    logic [7:0]    lights = 8'h00;
    logic          trigger = 1'b0;
    logic [CW-1:0] react_ms;
    logic          valid, jump_start, timeout, busy;
`ifdef F1_REACT_BEST_EN
    logic [CW-1:0] best_ms;
`endif

    int total = 0;
    int bad   = 0;

    // valid monitor: counts pulses and records what each one carried
    int vcnt     = 0;
    int vlast    = 0;
    int vtimeout = 0;

    f1_reaction_timer #(.CNT_WIDTH(CW), .TIMEOUT_MS(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_ms    (tick_ms),
        .lights     (lights),
        .trigger    (trigger),
        .react_ms   (react_ms),
        .valid      (valid),
        .jump_start (jump_start),
        .timeout    (timeout),
        .busy       (busy)
`ifdef F1_REACT_BEST_EN
        ,
        .best_ms    (best_ms)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            vcnt     = vcnt + 1;
            vlast    = int'(react_ms);
            vtimeout = int'(timeout);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick_ms = 1'b1;
        step();
        tick_ms = 1'b0;
        repeat ($urandom_range(0, 2)) step();
    endtask

    // Full start sequence, nticks ms of delay, then a press (or none when the
    // delay reaches the timeout). Reports what the valid monitor saw.
    task automatic do_run(input int nticks, input bit aligned, input int hold,
                          output int dv, output int vr, output int vt, output int bz);
        int v0;
        for (int i = 1; i <= 8; i++) begin
            lights = 8'((1 << i) - 1);
            step();
        end
        step();
        lights = 8'h00;
        step();
        bz = int'(busy);
        v0 = vcnt;
        if (nticks >= TMO) begin
            for (int k = 0; k < nticks + 5; k++) tick_pulse();
        end else begin
            for (int k = 0; k < nticks; k++) tick_pulse();
            trigger = 1'b1;
            if (aligned) begin
                step();
                step();
                tick_ms = 1'b1;
                step();
                tick_ms = 1'b0;
            end else begin
                repeat (3) step();
            end
            repeat (hold) step();
            trigger = 1'b0;
            repeat (4) step();
        end
        step();
        dv = vcnt - v0;
        vr = vlast;
        vt = vtimeout;
    endtask

    task automatic test_reset();
        #12;
        total++; if (react_ms !== '0) begin bad++; $display("FAIL reset_react got=%0d want=0", react_ms); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", valid); end
        total++; if (jump_start !== 1'b0) begin bad++; $display("FAIL reset_jump got=%0b want=0", jump_start); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b want=0", timeout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
`ifdef F1_REACT_BEST_EN
        total++; if (best_ms !== '1) begin bad++; $display("FAIL reset_best got=%0h want=ffff", best_ms); end
`endif
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int dv, vr, vt, bz;
        do_run(237, 1'b0, 5, dv, vr, vt, bz);
        total++; if (bz !== 1) begin bad++; $display("FAIL basic_busy_timing got=%0d want=1", bz); end
        total++; if (dv !== 1) begin bad++; $display("FAIL basic_valid_count got=%0d want=1", dv); end
        total++; if (vr !== 237) begin bad++; $display("FAIL basic_react got=%0d want=237", vr); end
        total++; if (vt !== 0) begin bad++; $display("FAIL basic_timeout got=%0d want=0", vt); end
        total++; if (react_ms !== 16'd237) begin bad++; $display("FAIL basic_held got=%0d want=237", react_ms); end
        total++; if (jump_start !== 1'b0) begin bad++; $display("FAIL basic_jump got=%0b want=0", jump_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%0b want=0", busy); end
    endtask

    task automatic test_random();
        int dv, vr, vt, bz, n, al, hd;
        for (int r = 0; r < 6; r++) begin
            n  = int'($urandom_range(0, 120));
            al = int'($urandom_range(0, 1));
            hd = int'($urandom_range(0, 30));
            do_run(n, al[0], hd, dv, vr, vt, bz);
            total++; if (dv !== 1) begin bad++; $display("FAIL rand%0d_valid_count got=%0d want=1", r, dv); end
            total++; if (vr !== n) begin bad++; $display("FAIL rand%0d_react got=%0d want=%0d", r, vr, n); end
            total++; if (vt !== 0) begin bad++; $display("FAIL rand%0d_timeout got=%0d want=0", r, vt); end
        end
    endtask

    task automatic test_aligned_hold();
        int dv, vr, vt, bz;
        do_run(50, 1'b1, 1000, dv, vr, vt, bz);
        total++; if (dv !== 1) begin bad++; $display("FAIL aligned_valid_count got=%0d want=1", dv); end
        total++; if (vr !== 50) begin bad++; $display("FAIL aligned_react got=%0d want=50", vr); end
    endtask

    task automatic test_timeout();
        int dv, vr, vt, bz;
        do_run(TMO, 1'b0, 0, dv, vr, vt, bz);
        total++; if (dv !== 1) begin bad++; $display("FAIL tmo_valid_count got=%0d want=1", dv); end
        total++; if (vr !== TMO) begin bad++; $display("FAIL tmo_react got=%0d want=%0d", vr, TMO); end
        total++; if (vt !== 1) begin bad++; $display("FAIL tmo_flag_at_valid got=%0d want=1", vt); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_level got=%0b want=1", timeout); end
        total++; if (react_ms !== 16'(TMO)) begin bad++; $display("FAIL tmo_held got=%0d want=%0d", react_ms, TMO); end
        lights = 8'h01;
        step();
        step();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%0b want=0", timeout); end
        total++; if (react_ms !== 16'(TMO)) begin bad++; $display("FAIL tmo_kept got=%0d want=%0d", react_ms, TMO); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tmo_rearm_busy got=%0b want=1", busy); end
        lights = 8'h00;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle_busy got=%0b want=0", busy); end
    endtask

    task automatic test_foul();
        int v0;
        int held;
        held = int'(react_ms);
        v0 = vcnt;
        for (int i = 1; i <= 4; i++) begin
            lights = 8'((1 << i) - 1);
            step();
        end
        trigger = 1'b1;
        repeat (6) step();
        total++; if (jump_start !== 1'b1) begin bad++; $display("FAIL foul_jump got=%0b want=1", jump_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL foul_busy got=%0b want=0", busy); end
        lights = 8'h1F;
        repeat (4) step();
        trigger = 1'b0;
        total++; if (jump_start !== 1'b1) begin bad++; $display("FAIL foul_stay_lit got=%0b want=1", jump_start); end
        lights = 8'h00;
        step();
        total++; if (jump_start !== 1'b1) begin bad++; $display("FAIL foul_stay_dark got=%0b want=1", jump_start); end
        lights = 8'h01;
        step();
        total++; if (jump_start !== 1'b0) begin bad++; $display("FAIL foul_exit_jump got=%0b want=0", jump_start); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL foul_exit_busy got=%0b want=1", busy); end
        total++; if (vcnt - v0 !== 0) begin bad++; $display("FAIL foul_no_valid got=%0d want=0", vcnt - v0); end
        total++; if (int'(react_ms) !== held) begin bad++; $display("FAIL foul_react_kept got=%0d want=%0d", react_ms, held); end
        lights = 8'h00;
        step();
        // In IDLE a press must be ignored
        trigger = 1'b1;
        repeat (5) step();
        trigger = 1'b0;
        repeat (3) step();
        total++; if (jump_start !== 1'b0) begin bad++; $display("FAIL idle_press_jump got=%0b want=0", jump_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_press_busy got=%0b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int dv, vr, vt, bz, n;
        for (int i = 1; i <= 8; i++) begin
            lights = 8'((1 << i) - 1);
            step();
        end
        lights = 8'h00;
        step();
        for (int k = 0; k < 100; k++) begin
            tick_ms = 1'b1;
            step();
        end
        tick_ms = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++; if (react_ms !== '0) begin bad++; $display("FAIL midrst_react got=%0d want=0", react_ms); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
        total++; if (valid !== 1'b0 || timeout !== 1'b0 || jump_start !== 1'b0) begin
            bad++; $display("FAIL midrst_flags got=%0b%0b%0b want=000", valid, timeout, jump_start);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        n = int'($urandom_range(1, 90));
        do_run(n, 1'b0, 2, dv, vr, vt, bz);
        total++; if (vr !== n || dv !== 1) begin bad++; $display("FAIL midrst_next_run got=%0d/%0d want=%0d/1", vr, dv, n); end
    endtask

`ifdef F1_REACT_BEST_EN
    task automatic test_best();
        int dv, vr, vt, bz;
        rst = 1'b0;
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        do_run(300, 1'b0, 2, dv, vr, vt, bz);
        total++; if (best_ms !== 16'd300) begin bad++; $display("FAIL best_first got=%0d want=300", best_ms); end
        do_run(180, 1'b1, 2, dv, vr, vt, bz);
        do_run(250, 1'b0, 2, dv, vr, vt, bz);
        do_run(TMO, 1'b0, 0, dv, vr, vt, bz);
        total++; if (best_ms !== 16'd180) begin bad++; $display("FAIL best_final got=%0d want=180", best_ms); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_aligned_hold();
        test_timeout();
        test_foul();
        test_reset_mid();
`ifdef F1_REACT_BEST_EN
        test_best();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
